sram_sp_param: RTL and testbench

Parametrised single-port synchronous SRAM: the successor to the team's fixed 8x8 SRAM, generalised in data width and depth. It adds byte-lane write enables, an explicit read strobe with a `rd_valid` qualifier, read-first behaviour on simultaneous read and write, and a hardware clear engine. The clear engine zeroes the array after reset and on request. It serves as the general local buffer and register-file store for datapath blocks.

---
 rtl/sram_sp_param.sv | 111 +++++++++++
 tb/tb_sram_sp_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_param.sv
// Parametrised single-port synchronous SRAM with byte lanes, read-first collisions
// and a clear engine. Define SRAM_OUT_REG_EN for an extra output register stage.
module sram_sp_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  dbg_state,
    output logic [ADDR_W-1:0]     dbg_clr_ptr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data;
    logic                rd_v;
    logic                rd_acc;

    // Strobe protocol: rd_en is accepted on any IDLE edge with no back-pressure;
    // rd_valid marks the single cycle in which dout carries that read's data.
    assign rd_acc      = (state == S_IDLE) && rd_en;
    assign dbg_state   = (state == S_CLEAR);
    assign dbg_clr_ptr = clr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (&clr_ptr) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (clr) begin
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= S_CLEAR;
                    busy    <= 1'b1;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // Array has no reset of its own; it is zeroed only by the clear walk.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Nonblocking read of mem gives read-first behaviour on a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_v    <= 1'b0;
        end else begin
            rd_v <= rd_acc;
            if (rd_acc) rd_data <= mem[addr];
        end
    end

`ifdef SRAM_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_v;
            if (rd_v) dout <= rd_data;
        end
    end
`else
    assign dout     = rd_data;
    assign rd_valid = rd_v;
`endif

endmodule

// File: tb/tb_sram_sp_param.sv
// Directed bench for sram_sp_param (DATA_W=16, ADDR_W=3); follows SRAM_OUT_REG_EN
// for the expected read latency.
module tb_sram_sp_param;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr   = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [1:0]        be    = '0;
    logic [DATA_W-1:0] din   = '0;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              busy;
    logic              dbg_state;
    logic [ADDR_W-1:0] dbg_clr_ptr;

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int nvalid  = 0;
    int first_v = -1;
    int last_v  = -1;
    int c0;
    int n0;
    logic [DATA_W-1:0] exp_q[$];

    sram_sp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .be(be), .din(din), .dout(dout), .rd_valid(rd_valid),
        .busy(busy), .dbg_state(dbg_state), .dbg_clr_ptr(dbg_clr_ptr)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the scoreboard pops an expected word on every rd_valid.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_valid === 1'b1) begin
            nvalid++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL rd_valid_unexpected: observed rd_valid=1, expected no pending read");
            end
            if (exp_q.size() != 0) check("rd_data", 32'(dout), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        be    = '0;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] b);
        wr_en = 1'b1; addr = a; din = d; be = b;
        step();
        idle();
    endtask

    task automatic read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) step();
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout: observed %0d pending reads, expected 0", exp_q.size());
        end
    endtask

    // Caller has already seen busy=1 for the first busy cycle; check the other DEPTH-1.
    task automatic wait_clear(input bit poke);
        for (int k = 1; k < DEPTH; k++) begin
            if (poke) begin
                wr_en = 1'b1; addr = 3'd2; din = 16'h5555; be = 2'b11;
                clr   = (k == 3);
            end
            step();
            check("busy_during_clear", 32'(busy), 32'd1);
        end
        if (poke) idle();
        step();
        check("busy_after_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_clr_ptr", 32'(dbg_clr_ptr), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd1);

        // Reset clear with rd_en held at addr 0
        rst_n = 1'b1; rd_en = 1'b1; addr = 3'd0;
        wait_clear(1'b0);
        exp_q.push_back(16'h0000);
        step();
        rd_en = 1'b0;
        drain();

        // Byte lanes and single-cycle rd_valid
        write(3'd3, 16'hA5A5, 2'b11);
        write(3'd3, 16'h1234, 2'b01);
        read(3'd3, 16'hA534);
        drain();
        step();
        check("rd_valid_single_pulse", 32'(rd_valid), 32'd0);
        check("dout_hold", 32'(dout), 32'hA534);
        write(3'd3, 16'hFFFF, 2'b00);
        read(3'd3, 16'hA534);
        drain();

        // Read-first collision
        write(3'd5, 16'h00FF, 2'b11);
        exp_q.push_back(16'h00FF);
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd5; din = 16'hBEEF; be = 2'b11;
        step();
        idle();
        read(3'd5, 16'hBEEF);
        drain();

        // Clear request with a write attempted and clr re-pulsed during busy
        for (int a = 0; a < DEPTH; a++) write(3'(a), 16'hFFFF, 2'b11);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy_start", 32'(busy), 32'd1);
        wait_clear(1'b1);
        n0 = nvalid;
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back(16'h0000);
            rd_en = 1'b1; addr = 3'(a);
            step();
        end
        rd_en = 1'b0;
        drain();
        check("clear_readback_count", 32'(nvalid - n0), 32'd8);

        // Reset mid-clear at clr_ptr=4, with a read completing alongside clr
        write(3'd6, 16'h1234, 2'b11);
        read(3'd6, 16'h1234);
        drain();
        exp_q.push_back(16'h1234);
        rd_en = 1'b1; clr = 1'b1; addr = 3'd6;
        step();
        idle();
        check("clr_with_read_busy", 32'(busy), 32'd1);
        repeat (4) step();
        check("mid_clear_ptr", 32'(dbg_clr_ptr), 32'd4);
        check("mid_clear_state", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        step();
        check("midclr_rst_busy", 32'(busy), 32'd1);
        check("midclr_rst_dout", 32'(dout), 32'd0);
        check("midclr_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("midclr_rst_ptr", 32'(dbg_clr_ptr), 32'd0);
        rst_n = 1'b1;
        wait_clear(1'b0);
        read(3'd6, 16'h0000);
        drain();

        // Reset mid-access squashes the in-flight read
        write(3'd2, 16'h4242, 2'b11);
        if (LAT == 1) exp_q.push_back(16'h4242);
        rd_en = 1'b1; addr = 3'd2;
        step();
        rd_en = 1'b0;
        rst_n = 1'b0;
        step();
        check("squash_rd_valid", 32'(rd_valid), 32'd0);
        check("squash_dout", 32'(dout), 32'd0);
        rst_n = 1'b1;
        wait_clear(1'b0);

        // Back-to-back reads: latency, contiguity and order
        for (int a = 0; a < DEPTH; a++) write(3'(a), 16'h1000 + 16'(a), 2'b11);
        first_v = -1;
        c0 = cyc;
        n0 = nvalid;
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back(16'h1000 + 16'(a));
            rd_en = 1'b1; addr = 3'(a);
            step();
        end
        rd_en = 1'b0;
        drain();
        check("burst_first_latency", 32'(first_v - c0), 32'(LAT));
        check("burst_count", 32'(nvalid - n0), 32'd8);
        check("burst_contiguous", 32'(last_v - first_v), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
